// File: rtl/impulse_sequencer.sv
// impulse_sequencer
//   Takes the parameter set from the SPI command receiver and plays out a gated
//   impulse burst for the DDS/TX gating logic. Each SPI_WR reloads the shadow
//   registers and re-arms, aborting any burst in progress. The burst starts when
//   SYS_TIME reaches TIME_START. It then emits N_impulse gate pulses of width Ti
//   and period Tp, and blanks the receiver through each pulse plus a tail.
//
//   Optional feature macro: IMPULSE_LATE_CHECK_EN
//     defined   : a TIME_START already in the past on the first armed tick rejects
//                 the burst and sets the sticky LATE flag
//     undefined : a late TIME_START starts at once and LATE stays 0
//
// Ports
//   clk, rst_n    system clock, async active-low reset
//   clk_en        tick enable for all timers and the FSM (SPI_WR bypasses it)
//   SYS_TIME      running system time in ticks
//   SPI_WR        load strobe for the parameter inputs below
//   TIME_START, N_impulse, TYPE_impulse, Interval_Ti, Interval_Tp, Tblank1, Tblank2
//   IMP_OUT       transmit gate
//   BLANK         receiver blank
//   TYPE_OUT      latched pulse type
//   IMP_CNT       pulses completed in the current burst
//   BUSY          burst armed or running
//   DONE          one-cycle strobe at normal burst end
//   LATE          sticky late-start flag
//
// state | meaning
// IDLE  | waiting for SPI_WR
// ARMED | waiting for SYS_TIME >= TIME_START
// PULSE | gate high, pulse-width timer running
// GAP   | gate low between pulses, blank tail may still run
// TAIL  | gate low after the final pulse, final blank tail running
module impulse_sequencer #(
    parameter int TW = 64,
    parameter int CW = 32,
    parameter int NW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clk_en,
    input  logic [TW-1:0] SYS_TIME,
    input  logic          SPI_WR,
    input  logic [TW-1:0] TIME_START,
    input  logic [NW-1:0] N_impulse,
    input  logic [7:0]    TYPE_impulse,
    input  logic [CW-1:0] Interval_Ti,
    input  logic [CW-1:0] Interval_Tp,
    input  logic [CW-1:0] Tblank1,
    input  logic [CW-1:0] Tblank2,
    output logic          IMP_OUT,
    output logic          BLANK,
    output logic [7:0]    TYPE_OUT,
    output logic [NW-1:0] IMP_CNT,
    output logic          BUSY,
    output logic          DONE,
    output logic          LATE
);

    typedef enum logic [2:0] {ST_IDLE, ST_ARMED, ST_PULSE, ST_GAP, ST_TAIL} state_t;

    localparam logic [CW-1:0] C_ONE = CW'(1);
    localparam logic [NW-1:0] N_ONE = NW'(1);

    state_t        state_q, state_d;
    logic [TW-1:0] ts_q;
    logic [NW-1:0] n_q;
    logic [7:0]    type_q;
    logic [CW-1:0] ti_q, tp_q, tb1_q, tb2_q;

    logic          imp_q, imp_d;
    logic          blank_q, blank_d;
    logic [CW-1:0] tmr_q, tmr_d;
    logic [CW-1:0] btmr_q, btmr_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          late_q, late_d;
    logic          late_reject;

    logic [CW-1:0] ti_e, gap;
    logic [NW-1:0] cnt_inc;
    logic          start_ok;

    // A zero width still gives a 1-tick pulse; a period not longer than the pulse
    // degrades to a 1-tick gap.
    assign ti_e     = (ti_q == '0) ? C_ONE : ti_q;
    assign gap      = (tp_q > ti_e) ? (tp_q - ti_e) : C_ONE;
    assign cnt_inc  = (cnt_q == '1) ? cnt_q : (cnt_q + N_ONE);
    assign start_ok = (ts_q == '0) || (SYS_TIME >= ts_q);

`ifdef IMPULSE_LATE_CHECK_EN
    logic first_q, first_d;
    assign late_reject = first_q && (ts_q != '0) && (SYS_TIME > ts_q);
`else
    assign late_reject = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_q   <= '0;
            n_q    <= '0;
            type_q <= '0;
            ti_q   <= '0;
            tp_q   <= '0;
            tb1_q  <= '0;
            tb2_q  <= '0;
        end else if (SPI_WR) begin
            ts_q   <= TIME_START;
            n_q    <= N_impulse;
            type_q <= TYPE_impulse;
            ti_q   <= Interval_Ti;
            tp_q   <= Interval_Tp;
            tb1_q  <= Tblank1;
            tb2_q  <= Tblank2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            imp_q   <= 1'b0;
            blank_q <= 1'b0;
            tmr_q   <= '0;
            btmr_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            late_q  <= 1'b0;
`ifdef IMPULSE_LATE_CHECK_EN
            first_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            imp_q   <= imp_d;
            blank_q <= blank_d;
            tmr_q   <= tmr_d;
            btmr_q  <= btmr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            late_q  <= late_d;
`ifdef IMPULSE_LATE_CHECK_EN
            first_q <= first_d;
`endif
        end
    end

    // tmr counts the remaining ticks of the current pulse/gap down to zero;
    // btmr counts the remaining blank-tail ticks and is discarded at pulse start.
    always_comb begin
        state_d = state_q;
        imp_d   = imp_q;
        blank_d = blank_q;
        tmr_d   = tmr_q;
        btmr_d  = btmr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        late_d  = late_q;
`ifdef IMPULSE_LATE_CHECK_EN
        first_d = first_q;
`endif
        if (SPI_WR) begin
            state_d = (N_impulse == '0) ? ST_IDLE : ST_ARMED;
            imp_d   = 1'b0;
            blank_d = 1'b0;
            tmr_d   = '0;
            btmr_d  = '0;
            cnt_d   = '0;
            late_d  = 1'b0;
`ifdef IMPULSE_LATE_CHECK_EN
            first_d = 1'b1;
`endif
        end else if (clk_en) begin
            case (state_q)
                ST_IDLE: ;
                ST_ARMED: begin
`ifdef IMPULSE_LATE_CHECK_EN
                    first_d = 1'b0;
`endif
                    if (late_reject) begin
                        state_d = ST_IDLE;
                        late_d  = 1'b1;
                    end else if (start_ok) begin
                        state_d = ST_PULSE;
                        imp_d   = 1'b1;
                        blank_d = 1'b1;
                        tmr_d   = ti_e - C_ONE;
                    end
                end
                ST_PULSE: begin
                    if (tmr_q == '0) begin
                        imp_d = 1'b0;
                        cnt_d = cnt_inc;
                        if (cnt_inc >= n_q) begin
                            state_d = ST_TAIL;
                            btmr_d  = tb2_q;
                            blank_d = (tb2_q != '0);
                        end else begin
                            state_d = ST_GAP;
                            tmr_d   = gap - C_ONE;
                            btmr_d  = tb1_q;
                            blank_d = (tb1_q != '0);
                        end
                    end else begin
                        tmr_d = tmr_q - C_ONE;
                    end
                end
                ST_GAP: begin
                    if (tmr_q == '0) begin
                        state_d = ST_PULSE;
                        imp_d   = 1'b1;
                        blank_d = 1'b1;
                        tmr_d   = ti_e - C_ONE;
                        btmr_d  = '0;
                    end else begin
                        tmr_d   = tmr_q - C_ONE;
                        blank_d = (btmr_q > C_ONE);
                        if (btmr_q != '0) btmr_d = btmr_q - C_ONE;
                    end
                end
                ST_TAIL: begin
                    if (btmr_q <= C_ONE) begin
                        state_d = ST_IDLE;
                        blank_d = 1'b0;
                        btmr_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        btmr_d = btmr_q - C_ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign IMP_OUT  = imp_q;
    assign BLANK    = blank_q;
    assign TYPE_OUT = type_q;
    assign IMP_CNT  = cnt_q;
    assign BUSY     = (state_q != ST_IDLE);
    assign DONE     = done_q;
    assign LATE     = late_q;

endmodule

// File: tb/tb_impulse_sequencer.sv
// tb_impulse_sequencer
//   Directed bench for impulse_sequencer. Outputs are sampled 1 ns after each
//   rising edge; SYS_TIME advances by one after every enabled edge, so the value
//   logged at a gate rise is the system time the DUT compared against.
module tb_impulse_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clk_en;
    logic [63:0] SYS_TIME;
    logic        SPI_WR;
    logic [63:0] TIME_START;
    logic [15:0] N_impulse;
    logic [7:0]  TYPE_impulse;
    logic [31:0] Interval_Ti, Interval_Tp, Tblank1, Tblank2;
    logic        IMP_OUT, BLANK, BUSY, DONE, LATE;
    logic [7:0]  TYPE_OUT;
    logic [15:0] IMP_CNT;

    int checks = 0;
    int errors = 0;

    // per-run observation log
    int     cyc, imp_cycles, n_rise, blank_run, n_runs, done_cycles, done_cyc;
    longint rise_t[8];
    int     rise_cyc[8];
    int     runs[8];
    logic   imp_prev;
    bit     duty4 = 1'b0;
    int     phase = 0;

    always #5 clk = ~clk;

    impulse_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clk_en       (clk_en),
        .SYS_TIME     (SYS_TIME),
        .SPI_WR       (SPI_WR),
        .TIME_START   (TIME_START),
        .N_impulse    (N_impulse),
        .TYPE_impulse (TYPE_impulse),
        .Interval_Ti  (Interval_Ti),
        .Interval_Tp  (Interval_Tp),
        .Tblank1      (Tblank1),
        .Tblank2      (Tblank2),
        .IMP_OUT      (IMP_OUT),
        .BLANK        (BLANK),
        .TYPE_OUT     (TYPE_OUT),
        .IMP_CNT      (IMP_CNT),
        .BUSY         (BUSY),
        .DONE         (DONE),
        .LATE         (LATE)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        cyc = 0; imp_cycles = 0; n_rise = 0; blank_run = 0; n_runs = 0;
        done_cycles = 0; done_cyc = -1;
        for (int i = 0; i < 8; i++) begin
            rise_t[i] = -1; rise_cyc[i] = -1; runs[i] = -1;
        end
        imp_prev = (IMP_OUT === 1'b1);
    endtask

    task automatic step();
        logic en_was;
        if (duty4) begin
            clk_en = (phase == 0);
            phase  = (phase + 1) % 4;
        end else begin
            clk_en = 1'b1;
        end
        en_was = clk_en;
        @(posedge clk);
        #1;
        cyc++;
        if (IMP_OUT === 1'b1) begin
            imp_cycles++;
            if (!imp_prev && n_rise < 8) begin
                rise_t[n_rise]   = SYS_TIME;
                rise_cyc[n_rise] = cyc;
                n_rise++;
            end
        end
        imp_prev = (IMP_OUT === 1'b1);
        if (BLANK === 1'b1) begin
            blank_run++;
        end else if (blank_run != 0) begin
            if (n_runs < 8) runs[n_runs] = blank_run;
            n_runs++;
            blank_run = 0;
        end
        if (DONE === 1'b1) begin
            done_cycles++;
            done_cyc = cyc;
        end
        if (en_was) SYS_TIME = SYS_TIME + 64'd1;
    endtask

    task automatic load(input logic [63:0] ts, input logic [15:0] n, input logic [7:0] ty,
                        input logic [31:0] ti, input logic [31:0] tp,
                        input logic [31:0] b1, input logic [31:0] b2);
        TIME_START = ts; N_impulse = n; TYPE_impulse = ty;
        Interval_Ti = ti; Interval_Tp = tp; Tblank1 = b1; Tblank2 = b2;
        SPI_WR = 1'b1;
        step();
        SPI_WR = 1'b0;
    endtask

    task automatic run_until_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            step();
            if (DONE === 1'b1) seen = 1'b1;
        end
        chk("done_within_budget", seen, 1);
    endtask

    initial begin
        rst_n = 1'b0; clk_en = 1'b0; SYS_TIME = 64'd0; SPI_WR = 1'b0;
        TIME_START = '0; N_impulse = '0; TYPE_impulse = '0;
        Interval_Ti = '0; Interval_Tp = '0; Tblank1 = '0; Tblank2 = '0;
        #12;
        chk("rst_imp_out", IMP_OUT, 0);
        chk("rst_blank", BLANK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_late", LATE, 0);
        chk("rst_type", TYPE_OUT, 0);
        chk("rst_cnt", IMP_CNT, 0);
        rst_n = 1'b1;
        step();
        chk("idle_busy", BUSY, 0);

        // 1: nominal burst, start at SYS_TIME=100
        SYS_TIME = 64'd90;
        load(64'd100, 16'd3, 8'hA5, 32'd4, 32'd10, 32'd2, 32'd5);
        chk("t1_busy_after_load", BUSY, 1);
        chk("t1_type_out", TYPE_OUT, 8'hA5);
        chk("t1_imp_armed", IMP_OUT, 0);
        clear_log();
        run_until_done(100);
        chk("t1_n_rise", n_rise, 3);
        chk("t1_rise0", rise_t[0], 100);
        chk("t1_rise1", rise_t[1], 110);
        chk("t1_rise2", rise_t[2], 120);
        chk("t1_imp_cycles", imp_cycles, 12);
        chk("t1_n_blank_runs", n_runs, 3);
        chk("t1_blank0", runs[0], 6);
        chk("t1_blank1", runs[1], 6);
        chk("t1_blank2", runs[2], 9);
        chk("t1_done_cycles", done_cycles, 1);
        chk("t1_imp_cnt", IMP_CNT, 3);
        step();
        chk("t1_done_clears", DONE, 0);
        chk("t1_idle", BUSY, 0);

        // 2: abort with N=0 in the middle of the second pulse
        load(64'd0, 16'd3, 8'h3C, 32'd4, 32'd10, 32'd2, 32'd5);
        clear_log();
        for (int i = 0; i < 50 && n_rise < 2; i++) step();
        chk("t2_reached_pulse2", n_rise, 2);
        step();
        chk("t2_mid_pulse_imp", IMP_OUT, 1);
        chk("t2_mid_pulse_cnt", IMP_CNT, 1);
        load(64'd0, 16'd0, 8'h00, 32'd4, 32'd10, 32'd2, 32'd5);
        chk("t2_abort_imp", IMP_OUT, 0);
        chk("t2_abort_blank", BLANK, 0);
        chk("t2_abort_busy", BUSY, 0);
        chk("t2_abort_cnt", IMP_CNT, 0);
        chk("t2_abort_done", DONE, 0);
        clear_log();
        repeat (20) step();
        chk("t2_no_done", done_cycles, 0);
        chk("t2_no_pulses", imp_cycles, 0);

        // 3: zero width / zero period degenerate to 1-tick pulse, 1-tick gap
        load(64'd0, 16'd2, 8'h01, 32'd0, 32'd0, 32'd0, 32'd0);
        clear_log();
        run_until_done(20);
        chk("t3_rise0_cyc", rise_cyc[0], 1);
        chk("t3_rise1_cyc", rise_cyc[1], 3);
        chk("t3_imp_cycles", imp_cycles, 2);
        chk("t3_n_blank_runs", n_runs, 2);
        chk("t3_blank0", runs[0], 1);
        chk("t3_blank1", runs[1], 1);
        chk("t3_done_cyc", done_cyc, 5);
        chk("t3_imp_cnt", IMP_CNT, 2);

        // 4: blank tail longer than the gap keeps BLANK high across the burst
        load(64'd0, 16'd3, 8'h02, 32'd4, 32'd10, 32'd20, 32'd5);
        clear_log();
        run_until_done(60);
        chk("t4_n_rise", n_rise, 3);
        chk("t4_rise2_cyc", rise_cyc[2], 21);
        chk("t4_n_blank_runs", n_runs, 1);
        chk("t4_blank_run", runs[0], 29);
        chk("t4_done_cyc", done_cyc, 30);

        // 5: profile of test 1 with clk_en at 1-of-4 duty
        SYS_TIME = 64'd90;
        duty4 = 1'b1; phase = 0;
        load(64'd100, 16'd3, 8'hA5, 32'd4, 32'd10, 32'd2, 32'd5);
        clear_log();
        run_until_done(400);
        chk("t5_n_rise", n_rise, 3);
        chk("t5_rise0", rise_t[0], 100);
        chk("t5_rise1", rise_t[1], 110);
        chk("t5_rise2", rise_t[2], 120);
        chk("t5_imp_cycles", imp_cycles, 48);
        chk("t5_blank0", runs[0], 24);
        chk("t5_blank1", runs[1], 24);
        chk("t5_blank2", runs[2], 36);
        chk("t5_done_cycles", done_cycles, 1);
        chk("t5_imp_cnt", IMP_CNT, 3);
        step();
        chk("t5_done_clears", DONE, 0);
        duty4 = 1'b0;

        // 7: SPI_WR on the terminal-count edge wins, no DONE
        load(64'd0, 16'd2, 8'h07, 32'd0, 32'd0, 32'd0, 32'd0);
        clear_log();
        repeat (4) step();
        chk("t7_busy_in_tail", BUSY, 1);
        chk("t7_cnt_in_tail", IMP_CNT, 2);
        load(64'd0, 16'd0, 8'h00, 32'd0, 32'd0, 32'd0, 32'd0);
        chk("t7_no_done", DONE, 0);
        chk("t7_idle", BUSY, 0);
        chk("t7_cnt_cleared", IMP_CNT, 0);
        step();
        chk("t7_no_done_later", DONE, 0);

        // 6: TIME_START already in the past at load
        SYS_TIME = 64'd60;
        load(64'd50, 16'd1, 8'h06, 32'd2, 32'd5, 32'd0, 32'd0);
        clear_log();
`ifdef IMPULSE_LATE_CHECK_EN
        repeat (10) step();
        chk("t6_no_pulses", n_rise, 0);
        chk("t6_late", LATE, 1);
        chk("t6_idle", BUSY, 0);
        chk("t6_no_done", done_cycles, 0);
        load(64'd0, 16'd1, 8'h06, 32'd2, 32'd5, 32'd0, 32'd0);
        chk("t6_late_cleared", LATE, 0);
        run_until_done(20);
`else
        run_until_done(20);
        chk("t6_n_rise", n_rise, 1);
        chk("t6_rise_time", rise_t[0], 61);
        chk("t6_rise_cyc", rise_cyc[0], 1);
        chk("t6_imp_cycles", imp_cycles, 2);
        chk("t6_late", LATE, 0);
`endif

        // async reset mid-pulse
        load(64'd0, 16'd1, 8'h99, 32'd4, 32'd10, 32'd0, 32'd0);
        step();
        chk("rst_mid_pulse_high", IMP_OUT, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_imp", IMP_OUT, 0);
        chk("async_rst_blank", BLANK, 0);
        chk("async_rst_busy", BUSY, 0);
        chk("async_rst_type", TYPE_OUT, 0);
        rst_n = 1'b1;
        step();
        chk("after_rst_idle", BUSY, 0);
        chk("after_rst_imp", IMP_OUT, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
